// File: rtl/stream_alu_fifo_if.sv
// Handshake bundle for stream_alu_fifo: operand side (in_*) and result side (out_*).
// slave = the arithmetic unit; master = stimulus producer / result consumer.
interface stream_alu_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_data;
    logic             out_ovf;
    logic [LW-1:0]    level;

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_ovf, level
    );

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, level
    );
endinterface

// File: rtl/stream_alu_fifo.sv
// Streaming ALU (ADD/SUB/ACC/CLR) with running accumulator feeding a result FIFO.
// Ports: clk, rst (async active-high), bus (stream_alu_fifo_if.slave).
// Optional macro STREAM_ALU_SAT_EN: saturating ADD/ACC and clamping SUB.
module stream_alu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    stream_alu_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [WIDTH:0] SAT_MAX = {1'b0, {WIDTH{1'b1}}};

`ifdef STREAM_ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } op_e;

    typedef struct packed {
        logic           ovf;
        logic [WIDTH:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             push;
    logic             pop;
    logic             in_ready;
    logic             out_valid;
    entry_t           res;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]   a_x, b_x, acc_x;
    logic [WIDTH:0]   sum_ab, diff_ab, sum_acc;
    logic             a_lt_b;

    // Ready depends only on registered occupancy: no full-bypass path.
    assign in_ready  = !rst && (level_q < FULL);
    assign out_valid = (level_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? mem_q[rd_ptr_q].data : '0;
    assign bus.out_ovf   = out_valid ? mem_q[rd_ptr_q].ovf : 1'b0;
    assign bus.level     = level_q;

    always_comb begin
        a_x     = {1'b0, bus.in_a};
        b_x     = {1'b0, bus.in_b};
        acc_x   = {1'b0, acc_q};
        sum_ab  = a_x + b_x;
        diff_ab = a_x - b_x;
        sum_acc = acc_x + a_x;
        a_lt_b  = (bus.in_a < bus.in_b);
        res     = '0;
        acc_nxt = acc_q;
        unique case (op_e'(bus.in_op))
            OP_ADD: begin
                res.data = sum_ab;
                res.ovf  = sum_ab[WIDTH];
                if (SAT_EN && sum_ab[WIDTH]) begin
                    res.data = SAT_MAX;
                end
            end
            OP_SUB: begin
                // Borrow flag is the unsigned compare, not diff MSB.
                res.data = diff_ab;
                res.ovf  = a_lt_b;
                if (SAT_EN && a_lt_b) begin
                    res.data = '0;
                end
            end
            OP_ACC: begin
                res.data = sum_acc;
                res.ovf  = sum_acc[WIDTH];
                acc_nxt  = sum_acc[WIDTH-1:0];
                if (SAT_EN && sum_acc[WIDTH]) begin
                    res.data = SAT_MAX;
                    acc_nxt  = {WIDTH{1'b1}};
                end
            end
            OP_CLR: begin
                // Report the value being cleared.
                res.data = acc_x;
                res.ovf  = 1'b0;
                acc_nxt  = '0;
            end
            default: begin
                res     = '0;
                acc_nxt = acc_q;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        acc_d    = acc_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = res;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            acc_d           = acc_nxt;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            acc_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: tb/tb_stream_alu_fifo.sv
// Directed + random scoreboard bench for stream_alu_fifo (WIDTH=8, DEPTH=4).
// Ports exercised through stream_alu_fifo_if; honours STREAM_ALU_SAT_EN.
module tb_stream_alu_fifo;
    localparam int W = 8;
    localparam int D = 4;
    localparam int MAXV = 255;

`ifdef STREAM_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic       ovf;
        logic [8:0] data;
    } res_t;

    logic clk;
    logic rst;

    stream_alu_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    stream_alu_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total;
    int   bad;
    int   npop;
    int   m_acc;
    res_t sb[$];
    res_t obs[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic res_t model(input logic [1:0] op, input int a, input int b);
        res_t r;
        int   s;
        r = '0;
        case (op)
            2'd0: begin
                s = a + b;
                r.data = 9'(s);
                r.ovf = (s > MAXV);
                if (SAT && s > MAXV) r.data = 9'(MAXV);
            end
            2'd1: begin
                r.data = 9'((a - b) & 32'h1FF);
                r.ovf = (a < b);
                if (SAT && a < b) r.data = 9'd0;
            end
            2'd2: begin
                s = m_acc + a;
                r.data = 9'(s);
                r.ovf = (s > MAXV);
                m_acc = s & MAXV;
                if (SAT && s > MAXV) begin
                    r.data = 9'(MAXV);
                    m_acc = MAXV;
                end
            end
            default: begin
                r.data = 9'(m_acc);
                r.ovf = 1'b0;
                m_acc = 0;
            end
        endcase
        return r;
    endfunction

    // Sample at negedge, then advance past the next rising edge.
    task automatic cycle(output bit accepted);
        res_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.in_op, int'(bus.in_a), int'(bus.in_b)));
            accepted = 1'b1;
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_data", 32'(bus.out_data), 32'(e.data));
                chk("sb_ovf", 32'(bus.out_ovf), 32'(e.ovf));
            end
            obs.push_back({bus.out_ovf, bus.out_data});
            npop++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input int a, input int b);
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = 8'(a);
        bus.in_b = 8'(b);
    endtask

    initial begin
        bit   acc;
        int   n;
        int   budget;
        int   p0;
        int   exp_acc[5];
        int   exp_ovf[5];
        total = 0;
        bad = 0;
        npop = 0;
        m_acc = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_op = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // ADD 200+100, one-cycle latency
        bus.out_ready = 1'b1;
        drive(2'd0, 200, 100);
        cycle(acc);
        chk("add_acc", 32'(acc), 32'd1);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_data", 32'(bus.out_data), SAT ? 32'hFF : 32'h12C);
        chk("add_ovf", 32'(bus.out_ovf), 32'd1);
        bus.in_valid = 1'b0;
        cycle(acc);

        // SUB 5-7
        drive(2'd1, 5, 7);
        cycle(acc);
        chk("sub_data", 32'(bus.out_data), SAT ? 32'h0 : 32'h1FE);
        chk("sub_ovf", 32'(bus.out_ovf), 32'd1);
        bus.in_valid = 1'b0;
        cycle(acc);
        chk("sub_empty", 32'(bus.out_valid), 32'd0);

        // ACC 10,20,250, CLR, ACC 1 back-to-back
        obs.delete();
        exp_acc = SAT ? '{10, 30, 255, 255, 1} : '{10, 30, 280, 24, 1};
        exp_ovf = '{0, 0, 1, 0, 0};
        drive(2'd2, 10, 99);
        cycle(acc);
        drive(2'd2, 20, 0);
        cycle(acc);
        drive(2'd2, 250, 7);
        cycle(acc);
        drive(2'd3, 0, 0);
        cycle(acc);
        drive(2'd2, 1, 0);
        cycle(acc);
        bus.in_valid = 1'b0;
        cycle(acc);
        chk("acc_count", 32'(obs.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            chk("acc_seq_data", 32'(obs[i].data), 32'(exp_acc[i]));
            chk("acc_seq_ovf", 32'(obs[i].ovf), 32'(exp_ovf[i]));
        end

        // Backpressure: 6 ADDs with out_ready low
        bus.out_ready = 1'b0;
        p0 = npop;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            drive(2'd0, n * 10 + 1, n * 3);
            cycle(acc);
            if (acc) n++;
        end
        chk("bp_accepted4", 32'(n), 32'd4);
        chk("bp_level4", 32'(bus.level), 32'd4);
        chk("bp_in_ready0", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            drive(2'd0, n * 10 + 1, n * 3);
            cycle(acc);
            chk("bp_stall_noacc", 32'(acc), 32'd0);
            chk("bp_stall_data", 32'(bus.out_data), 32'(sb[0].data));
            chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        budget = 0;
        while (n < 6 && budget < 20) begin
            drive(2'd0, n * 10 + 1, n * 3);
            cycle(acc);
            if (acc) n++;
            budget++;
        end
        chk("bp_accepted6", 32'(n), 32'd6);
        bus.in_valid = 1'b0;
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            cycle(acc);
            budget++;
        end
        chk("bp_drained", 32'(sb.size()), 32'd0);
        chk("bp_pops", 32'(npop - p0), 32'd6);
        chk("bp_level0", 32'(bus.level), 32'd0);

        // 100 random ops at full throughput
        p0 = npop;
        for (int k = 0; k < 100; k++) begin
            drive(2'($urandom_range(0, 3)), $urandom_range(0, 255), $urandom_range(0, 255));
            cycle(acc);
            chk("rnd_accept", 32'(acc), 32'd1);
            chk("rnd_level_le1", 32'(bus.level <= 1), 32'd1);
        end
        bus.in_valid = 1'b0;
        cycle(acc);
        chk("rnd_pops", 32'(npop - p0), 32'd100);
        chk("rnd_empty", 32'(bus.out_valid), 32'd0);

        // Reset mid-operation with level=3, acc=55
        bus.out_ready = 1'b0;
        drive(2'd3, 0, 0);
        cycle(acc);
        drive(2'd2, 55, 0);
        cycle(acc);
        drive(2'd0, 1, 1);
        cycle(acc);
        bus.in_valid = 1'b0;
        chk("mid_level3", 32'(bus.level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_level", 32'(bus.level), 32'd0);
        chk("mid_in_ready", 32'(bus.in_ready), 32'd0);
        sb.delete();
        m_acc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'd2, 1, 0);
        cycle(acc);
        chk("post_rst_acc", 32'(acc), 32'd1);
        chk("post_rst_data", 32'(bus.out_data), 32'd1);
        chk("post_rst_level", 32'(bus.level), 32'd1);
        bus.in_valid = 1'b0;
        cycle(acc);
        chk("post_rst_empty", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
